// File: rtl/boolean_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// boolean_sweep_ctrl
//
// Purpose: walks a 4-input combinational evaluator through all 16 input
// vectors, captures its two results (f1, f2) into truth tables, and then
// compares them against golden tables. Each vector is held on the vec
// outputs for one settle cycle before its results are captured.
//
// Ports:
//   clk          in   single clock, rising-edge active
//   rst_n        in   asynchronous active-low reset
//   start_i      in   request a full sweep (honoured only while idle)
//   abort_i      in   synchronous abort of a sweep in progress
//   vec_abcd_o   out  [3:0] vector to evaluator {A,B,C,D}, A = MSB
//   vec_wxyz_o   out  [3:0] same vector for the {w,x,y,z} inputs
//   f1_i, f2_i   in   evaluator results for the current vector
//   busy_o       out  high whenever a sweep is in progress
//   done_o       out  one-cycle pulse on sweep completion
//   f1_tt_o      out  [15:0] captured F1 truth table
//   f2_tt_o      out  [15:0] captured F2 truth table
//   f1_ones_o    out  [4:0] number of ones in the F1 table (0..16)
//   f2_ones_o    out  [4:0] number of ones in the F2 table (0..16)
//   f1_mis_o     out  [15:0] F1 table XOR golden (set bit = mismatch)
//   f2_mis_o     out  [15:0] F2 table XOR golden (set bit = mismatch)
//   pass_o       out  both mismatch masks zero after last completed sweep
//   aborted_o    out  last sweep was ended by abort
// ---------------------------------------------------------------------------
module boolean_sweep_ctrl #(
   parameter logic [15:0] F1_EXP = 16'h35A5,
   parameter logic [15:0] F2_EXP = 16'hF2E2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic        abort_i,
   output logic [3:0]  vec_abcd_o,
   output logic [3:0]  vec_wxyz_o,
   input  logic        f1_i,
   input  logic        f2_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] f1_tt_o,
   output logic [15:0] f2_tt_o,
   output logic [4:0]  f1_ones_o,
   output logic [4:0]  f2_ones_o,
   output logic [15:0] f1_mis_o,
   output logic [15:0] f2_mis_o,
   output logic        pass_o,
   output logic        aborted_o
);

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      CHECK,
      DONE
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  vec_q, vec_d;
   logic [15:0] f1Tt_q, f1Tt_d;
   logic [15:0] f2Tt_q, f2Tt_d;
   logic [15:0] f1Mis_q, f1Mis_d;
   logic [15:0] f2Mis_q, f2Mis_d;
   logic [4:0]  f1Ones_q, f1Ones_d;
   logic [4:0]  f2Ones_q, f2Ones_d;
   logic        pass_q, pass_d;
   logic        aborted_q, aborted_d;

   // Five-bit result so a table of all ones (16) is represented exactly.
   function automatic logic [4:0] popCount(input logic [15:0] v);
      logic [4:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, v[i]};
      end
      return cnt;
   endfunction

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= 4'd0;
         vec_q     <= 4'd0;
         f1Tt_q    <= 16'd0;
         f2Tt_q    <= 16'd0;
         f1Mis_q   <= 16'd0;
         f2Mis_q   <= 16'd0;
         f1Ones_q  <= 5'd0;
         f2Ones_q  <= 5'd0;
         pass_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         vec_q     <= vec_d;
         f1Tt_q    <= f1Tt_d;
         f2Tt_q    <= f2Tt_d;
         f1Mis_q   <= f1Mis_d;
         f2Mis_q   <= f2Mis_d;
         f1Ones_q  <= f1Ones_d;
         f2Ones_q  <= f2Ones_d;
         pass_q    <= pass_d;
         aborted_q <= aborted_d;
      end
   end

   // Next-state logic. Each state performs its datapath action (driving the
   // vector, capturing the results) even when abort is present; abort only
   // redirects the transition back to IDLE. That is why an abort in SAMPLE
   // still keeps the bit captured for the current index.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      vec_d     = vec_q;
      f1Tt_d    = f1Tt_q;
      f2Tt_d    = f2Tt_q;
      f1Mis_d   = f1Mis_q;
      f2Mis_d   = f2Mis_q;
      f1Ones_d  = f1Ones_q;
      f2Ones_d  = f2Ones_q;
      pass_d    = pass_q;
      aborted_d = aborted_q;

      case (state_q)
         IDLE: begin
            if (start_i && !abort_i) begin
               idx_d     = 4'd0;
               f1Tt_d    = 16'd0;
               f2Tt_d    = 16'd0;
               aborted_d = 1'b0;
               state_d   = DRIVE;
            end
         end

         DRIVE: begin
            vec_d = idx_q;
            if (abort_i) begin
               aborted_d = 1'b1;
               pass_d    = 1'b0;
               state_d   = IDLE;
            end else begin
               state_d = SAMPLE;
            end
         end

         SAMPLE: begin
            f1Tt_d[idx_q] = f1_i;
            f2Tt_d[idx_q] = f2_i;
            if (abort_i) begin
               aborted_d = 1'b1;
               pass_d    = 1'b0;
               state_d   = IDLE;
            end else if (idx_q == 4'd15) begin
               state_d = CHECK;
            end else begin
               idx_d   = idx_q + 4'd1;
               state_d = DRIVE;
            end
         end

         CHECK: begin
            if (abort_i) begin
               aborted_d = 1'b1;
               pass_d    = 1'b0;
               state_d   = IDLE;
            end else begin
               f1Mis_d  = f1Tt_q ^ F1_EXP;
               f2Mis_d  = f2Tt_q ^ F2_EXP;
               f1Ones_d = popCount(f1Tt_q);
               f2Ones_d = popCount(f2Tt_q);
               pass_d   = ((f1Tt_q ^ F1_EXP) == 16'd0) &&
                          ((f2Tt_q ^ F2_EXP) == 16'd0);
               state_d  = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign vec_abcd_o = vec_q;
   assign vec_wxyz_o = vec_q;
   assign busy_o     = (state_q != IDLE);
   assign done_o     = (state_q == DONE);
   assign f1_tt_o    = f1Tt_q;
   assign f2_tt_o    = f2Tt_q;
   assign f1_ones_o  = f1Ones_q;
   assign f2_ones_o  = f2Ones_q;
   assign f1_mis_o   = f1Mis_q;
   assign f2_mis_o   = f2Mis_q;
   assign pass_o     = pass_q;
   assign aborted_o  = aborted_q;

endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_boolean_sweep_ctrl
//
// Drives boolean_sweep_ctrl with an evaluator built from lookup tables and
// compares every output on every falling edge against a cycle-count model
// of a sweep: a sweep is 34 cycles long, odd cycles 1..31 present a vector,
// even cycles 2..32 capture it, cycle 33 evaluates, cycle 34 is DONE.
// ---------------------------------------------------------------------------
module tb_boolean_sweep_ctrl;

   localparam logic [15:0] F1_GOLD = 16'h35A5;
   localparam logic [15:0] F2_GOLD = 16'hF2E2;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [3:0]  vecAbcd;
   logic [3:0]  vecWxyz;
   logic        f1;
   logic        f2;
   logic        busy;
   logic        done;
   logic [15:0] f1Tt, f2Tt, f1Mis, f2Mis;
   logic [4:0]  f1Ones, f2Ones;
   logic        pass;
   logic        aborted;

   logic [15:0] f1Table;
   logic [15:0] f2Table;

   int vecCount  = 0;
   int failCount = 0;
   bit checkEn   = 1'b0;

   // Evaluator: a pure lookup of the current vector.
   assign f1 = f1Table[vecAbcd];
   assign f2 = f2Table[vecAbcd];

   boolean_sweep_ctrl #(
      .F1_EXP(F1_GOLD),
      .F2_EXP(F2_GOLD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start),
      .abort_i    (abort),
      .vec_abcd_o (vecAbcd),
      .vec_wxyz_o (vecWxyz),
      .f1_i       (f1),
      .f2_i       (f2),
      .busy_o     (busy),
      .done_o     (done),
      .f1_tt_o    (f1Tt),
      .f2_tt_o    (f2Tt),
      .f1_ones_o  (f1Ones),
      .f2_ones_o  (f2Ones),
      .f1_mis_o   (f1Mis),
      .f2_mis_o   (f2Mis),
      .pass_o     (pass),
      .aborted_o  (aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: k counts cycles into the current sweep (0 = idle).
   int          k;
   logic [3:0]  mVec;
   logic [15:0] mF1Tt, mF2Tt, mF1Mis, mF2Mis;
   logic [4:0]  mF1Ones, mF2Ones;
   logic        mPass, mAborted;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k        <= 0;
         mVec     <= 4'd0;
         mF1Tt    <= 16'd0;
         mF2Tt    <= 16'd0;
         mF1Mis   <= 16'd0;
         mF2Mis   <= 16'd0;
         mF1Ones  <= 5'd0;
         mF2Ones  <= 5'd0;
         mPass    <= 1'b0;
         mAborted <= 1'b0;
      end else if (k == 0) begin
         if (start && !abort) begin
            k        <= 1;
            mF1Tt    <= 16'd0;
            mF2Tt    <= 16'd0;
            mAborted <= 1'b0;
         end
      end else if (k <= 32) begin
         if (k % 2 == 1) begin
            mVec <= 4'((k - 1) / 2);
         end else begin
            mF1Tt[(k - 2) / 2] <= f1Table[mVec];
            mF2Tt[(k - 2) / 2] <= f2Table[mVec];
         end
         if (abort) begin
            k        <= 0;
            mAborted <= 1'b1;
            mPass    <= 1'b0;
         end else begin
            k <= k + 1;
         end
      end else if (k == 33) begin
         if (abort) begin
            k        <= 0;
            mAborted <= 1'b1;
            mPass    <= 1'b0;
         end else begin
            mF1Mis  <= mF1Tt ^ F1_GOLD;
            mF2Mis  <= mF2Tt ^ F2_GOLD;
            mF1Ones <= 5'($countones(mF1Tt));
            mF2Ones <= 5'($countones(mF2Tt));
            mPass   <= (mF1Tt == F1_GOLD) && (mF2Tt == F2_GOLD);
            k       <= 34;
         end
      end else begin
         k <= 0;
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
      vecCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Single compare process against the model.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("busy",    16'(busy),    16'(k != 0));
         checkOutput("done",    16'(done),    16'(k == 34));
         checkOutput("vecAbcd", 16'(vecAbcd), 16'(mVec));
         checkOutput("vecWxyz", 16'(vecWxyz), 16'(mVec));
         checkOutput("f1Tt",    f1Tt,         mF1Tt);
         checkOutput("f2Tt",    f2Tt,         mF2Tt);
         checkOutput("f1Mis",   f1Mis,        mF1Mis);
         checkOutput("f2Mis",   f2Mis,        mF2Mis);
         checkOutput("f1Ones",  16'(f1Ones),  16'(mF1Ones));
         checkOutput("f2Ones",  16'(f2Ones),  16'(mF2Ones));
         checkOutput("pass",    16'(pass),    16'(mPass));
         checkOutput("aborted", 16'(aborted), 16'(mAborted));
      end
   end

   task automatic applyStimulus(input logic s, input logic a);
      @(negedge clk);
      start = s;
      abort = a;
   endtask

   task automatic waitForK(input int target);
      int guard;
      guard = 0;
      while (k != target && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (k != target) begin
         vecCount++;
         failCount++;
         $display("[TB] FAIL waitForK: got k=%0d, expected %0d", k, target);
      end
   endtask

   // Launch one sweep and wait (bounded) for its done pulse.
   task automatic runSweep();
      int guard;
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      guard = 0;
      while (!done && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("sweepDone", 16'(done), 16'd1);
   endtask

   int doneCount;
   int firstDone;
   int secondDone;
   logic [3:0] vecHold;

   initial begin
      rst_n   = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      f1Table = F1_GOLD;
      f2Table = F2_GOLD;

      // Reset state.
      #1 rst_n = 1'b0;
      #2;
      checkEn = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rstBusy", 16'(busy), 16'd0);
      checkOutput("rstVec",  16'(vecAbcd), 16'd0);
      checkOutput("rstPass", 16'(pass), 16'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Golden sweep with exact done timing.
      applyStimulus(1'b1, 1'b0);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (32) @(posedge clk);
      #1 checkOutput("doneEarly", 16'(done), 16'd0);
      @(posedge clk);
      #1 checkOutput("doneAt34", 16'(done), 16'd1);
      checkOutput("goldF1Tt",   f1Tt, 16'h35A5);
      checkOutput("goldF2Tt",   f2Tt, 16'hF2E2);
      checkOutput("goldF1Ones", 16'(f1Ones), 16'd8);
      checkOutput("goldF2Ones", 16'(f2Ones), 16'd9);
      checkOutput("goldMis",    f1Mis | f2Mis, 16'd0);
      checkOutput("goldPass",   16'(pass), 16'd1);
      repeat (3) @(negedge clk);

      // F1 stuck at zero.
      f1Table = 16'h0000;
      runSweep();
      checkOutput("stuckF1Tt",   f1Tt, 16'h0000);
      checkOutput("stuckF1Mis",  f1Mis, 16'h35A5);
      checkOutput("stuckF1Ones", 16'(f1Ones), 16'd0);
      checkOutput("stuckPass",   16'(pass), 16'd0);
      checkOutput("stuckF2Tt",   f2Tt, 16'hF2E2);
      checkOutput("stuckF2Ones", 16'(f2Ones), 16'd9);
      repeat (3) @(negedge clk);

      // Golden sweep then abort in SAMPLE with idx 5.
      f1Table = F1_GOLD;
      runSweep();
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      waitForK(12);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      checkOutput("abBusy",    16'(busy), 16'd0);
      checkOutput("abAborted", 16'(aborted), 16'd1);
      checkOutput("abPass",    16'(pass), 16'd0);
      checkOutput("abF1Tt",    f1Tt, 16'h0025);
      checkOutput("abF2Tt",    f2Tt, 16'h0022);
      doneCount = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("abNoDone", 16'(doneCount), 16'd0);

      // start and abort together while idle.
      vecHold = vecAbcd;
      repeat (5) applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("saBusy", 16'(busy), 16'd0);
      checkOutput("saVec",  16'(vecAbcd), 16'(vecHold));

      // start held high: back-to-back sweeps every 35 cycles.
      applyStimulus(1'b1, 1'b0);
      doneCount  = 0;
      firstDone  = 0;
      secondDone = 0;
      for (int i = 1; i <= 150; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            doneCount++;
            if (doneCount == 1) firstDone = i;
            if (doneCount == 2) secondDone = i;
         end
      end
      checkOutput("b2bCount",  16'(doneCount), 16'd4);
      checkOutput("b2bFirst",  16'(firstDone), 16'd34);
      checkOutput("b2bPeriod", 16'(secondDone - firstDone), 16'd35);
      applyStimulus(1'b0, 1'b0);
      waitForK(0);

      // Asynchronous reset at idx 9.
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      waitForK(20);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arBusy", 16'(busy), 16'd0);
      checkOutput("arVec",  16'(vecAbcd), 16'd0);
      checkOutput("arTt",   f1Tt | f2Tt, 16'd0);
      checkOutput("arOnes", 16'(f1Ones | f2Ones), 16'd0);
      checkOutput("arPass", 16'(pass), 16'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      doneCount = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("arNoDone", 16'(doneCount), 16'd0);
      runSweep();
      checkOutput("arPassAfter", 16'(pass), 16'd1);
      repeat (2) @(negedge clk);

      // Randomized traffic with random evaluator tables.
      for (int n = 0; n < 2500; n++) begin
         if (k == 0 && ($urandom % 3) == 0) begin
            if (($urandom % 4) == 0) begin
               f1Table = F1_GOLD;
               f2Table = F2_GOLD;
            end else begin
               f1Table = 16'($urandom);
               f2Table = 16'($urandom);
            end
         end
         applyStimulus(($urandom % 4) == 0, ($urandom % 40) == 0);
      end
      applyStimulus(1'b0, 1'b0);
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
      $finish;
   end

endmodule
